// File: rtl/hdc_regs_pkg.sv
// Shared definitions for the HDC control/status register file: register map,
// field positions, AXI response codes, slave FSM states and small helpers.
package hdc_regs_pkg;

  // Word offsets (byte address >> 2) of the implemented registers
  localparam int unsigned OFF_CTRL       = 0;
  localparam int unsigned OFF_ITEM_NUM   = 1;
  localparam int unsigned OFF_RESET_ITEM = 2;
  localparam int unsigned OFF_STATUS     = 3;
  localparam int unsigned OFF_IRQ_EN     = 4;
  localparam int unsigned OFF_IRQ_STAT   = 5;
  localparam int unsigned OFF_CYCLES     = 6;

  // Field bit positions
  localparam int unsigned CTRL_GEN_BIT  = 0;
  localparam int unsigned CTRL_RUN_BIT  = 1;
  localparam int unsigned STAT_DONE_BIT = 2;
  localparam int unsigned IRQ_DONE_BIT  = 0;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_WR,
    ST_BRSP,
    ST_RD,
    ST_RRSP
  } axil_state_t;

  // True when a (already ADDR_W-truncated) byte address falls beyond the register bank
  function automatic logic offset_err(input logic [31:0] byte_addr, input int unsigned nreg);
    return (byte_addr >> 2) >= 32'(nreg);
  endfunction

endpackage

// File: rtl/hdc_axil_slave_fsm.sv
// AXI4-Lite slave handshake engine. Accepts AW/W in either order, commits a
// write for exactly one cycle, returns responses, and captures read data one
// cycle after the read address is taken. Writes take priority over reads.
module hdc_axil_slave_fsm
  import hdc_regs_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       S_AXI_AWADDR,
  input  logic              S_AXI_AWVALID,
  output logic              S_AXI_AWREADY,
  input  logic [31:0]       S_AXI_WDATA,
  input  logic [3:0]        S_AXI_WSTRB,
  input  logic              S_AXI_WVALID,
  output logic              S_AXI_WREADY,
  output logic [1:0]        S_AXI_BRESP,
  output logic              S_AXI_BVALID,
  input  logic              S_AXI_BREADY,
  input  logic [31:0]       S_AXI_ARADDR,
  input  logic              S_AXI_ARVALID,
  output logic              S_AXI_ARREADY,
  output logic [31:0]       S_AXI_RDATA,
  output logic [1:0]        S_AXI_RRESP,
  output logic              S_AXI_RVALID,
  input  logic              S_AXI_RREADY,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [3:0]        wr_strb,
  input  logic              wr_err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  input  logic              rd_err
);

  axil_state_t       state_reg, state_next;
  logic [ADDR_W-1:0] awaddr_reg, araddr_reg;
  logic [31:0]       wdata_reg, rdata_reg;
  logic [3:0]        wstrb_reg;
  logic [1:0]        bresp_reg, rresp_reg;

  // Address bits above ADDR_W are deliberately ignored
  logic unused_addr_bits;
  assign unused_addr_bits = ^{S_AXI_AWADDR[31:ADDR_W], S_AXI_ARADDR[31:ADDR_W]};

  // Next-state and ready generation; AR is held off whenever a write is pending
  always_comb begin
    state_next    = state_reg;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_ARREADY = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        S_AXI_AWREADY = 1'b1;
        S_AXI_WREADY  = 1'b1;
        S_AXI_ARREADY = !S_AXI_AWVALID && !S_AXI_WVALID;
        if (S_AXI_AWVALID && S_AXI_WVALID) state_next = ST_WR;
        else if (S_AXI_AWVALID)            state_next = ST_AW;
        else if (S_AXI_WVALID)             state_next = ST_W;
        else if (S_AXI_ARVALID)            state_next = ST_RD;
      end
      ST_AW: begin
        S_AXI_WREADY = 1'b1;
        if (S_AXI_WVALID) state_next = ST_WR;
      end
      ST_W: begin
        S_AXI_AWREADY = 1'b1;
        if (S_AXI_AWVALID) state_next = ST_WR;
      end
      ST_WR:   state_next = ST_BRSP;
      ST_BRSP: if (S_AXI_BREADY) state_next = ST_IDLE;
      ST_RD:   state_next = ST_RRSP;
      ST_RRSP: if (S_AXI_RREADY) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // State register plus capture of address/data/response holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      awaddr_reg <= '0;
      araddr_reg <= '0;
      wdata_reg  <= '0;
      wstrb_reg  <= '0;
      bresp_reg  <= RESP_OKAY;
      rdata_reg  <= '0;
      rresp_reg  <= RESP_OKAY;
    end else begin
      state_reg <= state_next;
      if (S_AXI_AWVALID && S_AXI_AWREADY) awaddr_reg <= S_AXI_AWADDR[ADDR_W-1:0];
      if (S_AXI_WVALID && S_AXI_WREADY) begin
        wdata_reg <= S_AXI_WDATA;
        wstrb_reg <= S_AXI_WSTRB;
      end
      if (S_AXI_ARVALID && S_AXI_ARREADY) araddr_reg <= S_AXI_ARADDR[ADDR_W-1:0];
      if (state_reg == ST_WR) bresp_reg <= wr_err ? RESP_SLVERR : RESP_OKAY;
      if (state_reg == ST_RD) begin
        rdata_reg <= rd_err ? 32'd0 : rd_data;
        rresp_reg <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign S_AXI_BVALID = (state_reg == ST_BRSP);
  assign S_AXI_BRESP  = bresp_reg;
  assign S_AXI_RVALID = (state_reg == ST_RRSP);
  assign S_AXI_RDATA  = rdata_reg;
  assign S_AXI_RRESP  = rresp_reg;

  assign wr_en   = (state_reg == ST_WR);
  assign wr_addr = awaddr_reg;
  assign wr_data = wdata_reg;
  assign wr_strb = wstrb_reg;
  assign rd_en   = (state_reg == ST_RD);
  assign rd_addr = araddr_reg;

endmodule

// File: rtl/hdc_ctrl_regs.sv
// HDC accelerator control/status register file behind an AXI4-Lite slave.
// Holds run/gen/item count controls, sticky done with W1C interrupt status,
// and a saturating cycle counter for the current run.
module hdc_ctrl_regs
  import hdc_regs_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int NREG   = 8,
  parameter int IMN_W  = 9,
  parameter int CYC_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      S_AXI_AWADDR,
  input  logic             S_AXI_AWVALID,
  output logic             S_AXI_AWREADY,
  input  logic [31:0]      S_AXI_WDATA,
  input  logic [3:0]       S_AXI_WSTRB,
  input  logic             S_AXI_WVALID,
  output logic             S_AXI_WREADY,
  output logic [1:0]       S_AXI_BRESP,
  output logic             S_AXI_BVALID,
  input  logic             S_AXI_BREADY,
  input  logic [31:0]      S_AXI_ARADDR,
  input  logic             S_AXI_ARVALID,
  output logic             S_AXI_ARREADY,
  output logic [31:0]      S_AXI_RDATA,
  output logic [1:0]       S_AXI_RRESP,
  output logic             S_AXI_RVALID,
  input  logic             S_AXI_RREADY,
  output logic             run,
  output logic             gen,
  output logic [IMN_W-1:0] item_memory_num,
  output logic             reset_item,
  input  logic             gen_done,
  input  logic             run_done,
  output logic             irq
);

  logic              wr_en, wr_err, rd_en, rd_err;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [31:0]       wr_data, rd_data;
  logic [3:0]        wr_strb;
  logic [ADDR_W-3:0] wr_off, rd_off;

  logic              gen_reg, gen_next, run_reg, run_next;
  logic [IMN_W-1:0]  item_num_reg, item_num_next, item_num_wval;
  logic              reset_item_reg, reset_item_next;
  logic              irq_en_reg, irq_en_next;
  logic              done_reg, done_next;
  logic [CYC_W-1:0]  cyc_reg, cyc_next;

  logic ctrl_we, item_we, rst_item_we, irq_en_we, irq_stat_we;
  logic run_rise, done_set, done_clr;

  hdc_axil_slave_fsm #(.ADDR_W(ADDR_W)) u_fsm (
    .clk           (clk),
    .rst           (rst),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_strb       (wr_strb),
    .wr_err        (wr_err),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_err        (rd_err)
  );

  assign wr_err = offset_err(32'(wr_addr), NREG);
  assign rd_err = offset_err(32'(rd_addr), NREG);
  assign wr_off = wr_addr[ADDR_W-1:2];
  assign rd_off = rd_addr[ADDR_W-1:2];

  // Only the low data bits / strobes matter for the narrow fields
  logic unused_wr_bits;
  assign unused_wr_bits = ^{wr_data, wr_strb};

  // Per-register commit strobes; an errored address never writes anything
  assign ctrl_we     = wr_en && !wr_err && (wr_off == (ADDR_W-2)'(OFF_CTRL));
  assign item_we     = wr_en && !wr_err && (wr_off == (ADDR_W-2)'(OFF_ITEM_NUM));
  assign rst_item_we = wr_en && !wr_err && (wr_off == (ADDR_W-2)'(OFF_RESET_ITEM));
  assign irq_en_we   = wr_en && !wr_err && (wr_off == (ADDR_W-2)'(OFF_IRQ_EN));
  assign irq_stat_we = wr_en && !wr_err && (wr_off == (ADDR_W-2)'(OFF_IRQ_STAT));

  // Byte-lane merge of the item count: each bit follows the strobe of its byte
  genvar gi;
  generate
    for (gi = 0; gi < IMN_W; gi++) begin : g_item_bits
      assign item_num_wval[gi] = wr_strb[gi/8] ? wr_data[gi] : item_num_reg[gi];
    end
  endgenerate

  assign run_rise = ctrl_we && wr_strb[0] && wr_data[CTRL_RUN_BIT] && !run_reg;
  assign done_set = run_done && run_reg;
  assign done_clr = (irq_stat_we && wr_strb[0] && wr_data[IRQ_DONE_BIT]) || run_rise;

  // Next values of the register bank; a CTRL write overrides gen auto-clear
  always_comb begin
    gen_next        = gen_reg;
    run_next        = run_reg;
    item_num_next   = item_num_reg;
    reset_item_next = reset_item_reg;
    irq_en_next     = irq_en_reg;
    cyc_next        = cyc_reg;
    if (gen_reg && gen_done) gen_next = 1'b0;
    if (ctrl_we && wr_strb[0]) begin
      gen_next = wr_data[CTRL_GEN_BIT];
      run_next = wr_data[CTRL_RUN_BIT];
    end
    if (item_we) item_num_next = item_num_wval;
    if (rst_item_we && wr_strb[0]) reset_item_next = wr_data[0];
    if (irq_en_we && wr_strb[0]) irq_en_next = wr_data[0];
    done_next = done_set || (done_reg && !done_clr);
    if (run_rise) cyc_next = '0;
    else if (run_reg && (cyc_reg != {CYC_W{1'b1}})) cyc_next = cyc_reg + CYC_W'(1);
  end

  // Register bank state
  always_ff @(posedge clk) begin
    if (rst) begin
      gen_reg        <= 1'b0;
      run_reg        <= 1'b0;
      item_num_reg   <= '0;
      reset_item_reg <= 1'b0;
      irq_en_reg     <= 1'b0;
      done_reg       <= 1'b0;
      cyc_reg        <= '0;
    end else begin
      gen_reg        <= gen_next;
      run_reg        <= run_next;
      item_num_reg   <= item_num_next;
      reset_item_reg <= reset_item_next;
      irq_en_reg     <= irq_en_next;
      done_reg       <= done_next;
      cyc_reg        <= cyc_next;
    end
  end

  // Read mux; reserved and unimplemented bits read as zero
  always_comb begin
    rd_data = 32'd0;
    if (rd_en) begin
      case (rd_off)
        (ADDR_W-2)'(OFF_CTRL): begin
          rd_data[CTRL_GEN_BIT] = gen_reg;
          rd_data[CTRL_RUN_BIT] = run_reg;
        end
        (ADDR_W-2)'(OFF_ITEM_NUM):   rd_data = 32'(item_num_reg);
        (ADDR_W-2)'(OFF_RESET_ITEM): rd_data[0] = reset_item_reg;
        (ADDR_W-2)'(OFF_STATUS): begin
          rd_data[CTRL_GEN_BIT]  = gen_reg;
          rd_data[CTRL_RUN_BIT]  = run_reg;
          rd_data[STAT_DONE_BIT] = done_reg;
        end
        (ADDR_W-2)'(OFF_IRQ_EN):     rd_data[0] = irq_en_reg;
        (ADDR_W-2)'(OFF_IRQ_STAT):   rd_data[IRQ_DONE_BIT] = done_reg;
        (ADDR_W-2)'(OFF_CYCLES):     rd_data = 32'(cyc_reg);
        default:                     rd_data = 32'd0;
      endcase
    end
  end

  assign gen             = gen_reg;
  assign run             = run_reg;
  assign item_memory_num = item_num_reg;
  assign reset_item      = reset_item_reg;
  assign irq             = irq_en_reg && done_reg;

endmodule

// File: tb/tb_hdc_ctrl_regs.sv
// Directed bench for hdc_ctrl_regs: AXI-Lite handshakes, decode errors,
// strobes, gen auto-clear, sticky done / W1C irq, cycle counter and reset.
module tb_hdc_ctrl_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        run, gen, reset_item, gen_done, run_done, irq;
  logic [8:0]  item_memory_num;

  int n_checks = 0;
  int n_errs   = 0;

  logic [1:0]  resp;
  logic [31:0] data;
  logic        got, acc;

  always #5 clk = ~clk;

  hdc_ctrl_regs #(.ADDR_W(12), .NREG(8), .IMN_W(9), .CYC_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .S_AXI_AWADDR    (awaddr),
    .S_AXI_AWVALID   (awvalid),
    .S_AXI_AWREADY   (awready),
    .S_AXI_WDATA     (wdata),
    .S_AXI_WSTRB     (wstrb),
    .S_AXI_WVALID    (wvalid),
    .S_AXI_WREADY    (wready),
    .S_AXI_BRESP     (bresp),
    .S_AXI_BVALID    (bvalid),
    .S_AXI_BREADY    (bready),
    .S_AXI_ARADDR    (araddr),
    .S_AXI_ARVALID   (arvalid),
    .S_AXI_ARREADY   (arready),
    .S_AXI_RDATA     (rdata),
    .S_AXI_RRESP     (rresp),
    .S_AXI_RVALID    (rvalid),
    .S_AXI_RREADY    (rready),
    .run             (run),
    .gen             (gen),
    .item_memory_num (item_memory_num),
    .reset_item      (reset_item),
    .gen_done        (gen_done),
    .run_done        (run_done),
    .irq             (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got_val, input logic [31:0] exp_val);
    n_checks++;
    if (got_val !== exp_val) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got_val, exp_val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // AW and W presented together, BREADY held high
  task automatic axi_write(input logic [31:0] addr, input logic [31:0] d,
                           input logic [3:0] strb, output logic [1:0] r);
    logic seen;
    seen = 1'b0;
    r = 2'b11;
    awaddr = addr; wdata = d; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (bvalid) begin
        seen = 1'b1;
        r = bresp;
      end else tick();
    end
    chk("wr_bvalid_seen", 32'(seen), 32'd1);
    tick();
    bready = 1'b0;
    $display("write addr=0x%08h data=0x%08h strb=%b bresp=%b", addr, d, strb, r);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    logic seen;
    seen = 1'b0;
    d = 32'hDEAD_BEEF; r = 2'b11;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      if (rvalid) begin
        seen = 1'b1;
        d = rdata;
        r = rresp;
      end else tick();
    end
    chk("rd_rvalid_seen", 32'(seen), 32'd1);
    tick();
    rready = 1'b0;
    $display("read  addr=0x%08h data=0x%08h rresp=%b", addr, d, r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    gen_done = 1'b0; run_done = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_awready", 32'(awready), 32'd1);
    chk("rst_wready", 32'(wready), 32'd1);
    chk("rst_arready", 32'(arready), 32'd1);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_outs", {26'd0, irq, reset_item, run, gen, bresp}, 32'd0);
    chk("rst_item", 32'(item_memory_num), 32'd0);
    rst = 1'b0;
    tick();

    // AW+W same cycle: BVALID seen at the second edge after acceptance
    awaddr = 32'h04; wdata = 32'h1FF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t1_bvalid_early", 32'(bvalid), 32'd0);
    tick();
    chk("t1_bvalid", 32'(bvalid), 32'd1);
    chk("t1_bresp", 32'(bresp), 32'd0);
    chk("t1_item", 32'(item_memory_num), 32'h1FF);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("t1_bvalid_done", 32'(bvalid), 32'd0);
    $display("write addr=0x00000004 data=0x000001ff strb=1111 bresp=00");

    // W first, AW three cycles later, BREADY held low; gen_done pulse clears gen
    awaddr = 32'h00; wdata = 32'h1; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("t2_wready_held", 32'(wready), 32'd0);
    tick();
    tick();
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("t2_gen_before_commit", 32'(gen), 32'd0);
    tick();
    chk("t2_gen_set", 32'(gen), 32'd1);
    chk("t2_bvalid", 32'(bvalid), 32'd1);
    gen_done = 1'b1;
    tick();
    gen_done = 1'b0;
    chk("t3_gen_autoclear", 32'(gen), 32'd0);
    tick();
    tick();
    chk("t2_bvalid_held", 32'(bvalid), 32'd1);
    chk("t2_single_commit", 32'(gen), 32'd0);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("t2_bvalid_done", 32'(bvalid), 32'd0);
    $display("write addr=0x00000000 data=0x00000001 strb=1111 bresp=00 (W before AW)");

    // STATUS read with latency check: RVALID low after edge n, high by edge n+2
    araddr = 32'h0C; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("t3_rvalid_early", 32'(rvalid), 32'd0);
    tick();
    chk("t3_rvalid", 32'(rvalid), 32'd1);
    chk("t3_status", rdata, 32'd0);
    chk("t3_rresp", 32'(rresp), 32'd0);
    tick();
    rready = 1'b0;
    chk("t3_rvalid_done", 32'(rvalid), 32'd0);
    $display("read  addr=0x0000000c data=0x00000000 rresp=00");

    // Cycle counter: zero at the commit edge, +1 per edge -> 22 at the capture edge
    axi_write(32'h10, 32'h1, 4'hF, resp);
    axi_write(32'h00, 32'h2, 4'hF, resp);
    repeat (20) tick();
    axi_read(32'h18, data, resp);
    chk("t4_cycles", data, 32'd22);
    chk("t4_run", 32'(run), 32'd1);

    // Sticky done and irq, W1C behaviour
    run_done = 1'b1;
    tick();
    run_done = 1'b0;
    chk("t4_irq_set", 32'(irq), 32'd1);
    axi_read(32'h14, data, resp);
    chk("t4_irq_stat", data, 32'd1);
    axi_write(32'h14, 32'h1, 4'h0, resp);
    chk("t4_w1c_nostrb", 32'(irq), 32'd1);
    axi_write(32'h14, 32'h1, 4'hF, resp);
    chk("t4_w1c_clear", 32'(irq), 32'd0);
    awaddr = 32'h14; wdata = 32'h1; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    run_done = 1'b1;
    tick();
    run_done = 1'b0;
    chk("t4_set_wins", 32'(irq), 32'd1);
    tick();
    bready = 1'b0;
    $display("write addr=0x00000014 data=0x00000001 strb=1111 with run_done same cycle");

    // Strobes and decode errors
    axi_write(32'h04, 32'h0000_0012, 4'h1, resp);
    chk("t5_strb_lane0", 32'(item_memory_num), 32'h112);
    axi_write(32'h04, 32'h0, 4'h0, resp);
    chk("t5_strb_none", 32'(item_memory_num), 32'h112);
    axi_write(32'h40, 32'hFFFF_FFFF, 4'hF, resp);
    chk("t5_wr_slverr", 32'(resp), 32'h2);
    chk("t5_wr_noeffect", {29'd0, item_memory_num == 9'h112, run, gen}, 32'h6);
    axi_read(32'h40, data, resp);
    chk("t5_rd_slverr", 32'(resp), 32'h2);
    chk("t5_rd_zero", data, 32'd0);
    axi_read(32'h1C, data, resp);
    chk("t5_reserved", {data[29:0], resp}, 32'd0);
    axi_read(32'h1004, data, resp);
    chk("t5_upper_ignored", data, 32'h112);

    // Simultaneous AW/W/AR: write goes first, read returns the new value
    awaddr = 32'h04; wdata = 32'h055; wstrb = 4'hF; araddr = 32'h04;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    #1;
    chk("t6_arready_blocked", 32'(arready), 32'd0);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 12 && !got; i++) begin
      if (rvalid) begin
        got = 1'b1;
        data = rdata;
      end else begin
        acc = arready && arvalid;
        tick();
        if (acc) arvalid = 1'b0;
      end
    end
    chk("t6_rvalid_seen", 32'(got), 32'd1);
    chk("t6_write_first", data, 32'h055);
    tick();
    bready = 1'b0; rready = 1'b0; arvalid = 1'b0;
    $display("write+read addr=0x00000004 data=0x00000055 read=0x%08h", data);

    // Reset during BRSP
    awaddr = 32'h08; wdata = 32'h1; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk("t7_brsp", {30'd0, bvalid, reset_item}, 32'h3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_bvalid_rst", 32'(bvalid), 32'd0);
    chk("t7_regs_rst", {22'd0, item_memory_num, reset_item}, 32'd0);
    chk("t7_outs_rst", {28'd0, irq, run, gen, awready}, 32'd1);
    $display("write addr=0x00000008 abandoned by reset in BRSP");
    tick();

    // Reset during RRSP
    axi_write(32'h04, 32'h0AA, 4'hF, resp);
    araddr = 32'h04; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    tick();
    chk("t8_rrsp", {rvalid, 22'd0, rdata[8:0]}, 32'h8000_00AA);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t8_rvalid_rst", 32'(rvalid), 32'd0);
    chk("t8_rdata_rst", rdata, 32'd0);
    chk("t8_item_rst", 32'(item_memory_num), 32'd0);
    $display("read  addr=0x00000004 abandoned by reset in RRSP");
    tick();
    axi_read(32'h18, data, resp);
    chk("t8_cycles_rst", data, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
